// File: rtl/click_pkg.sv
// rtl/click_pkg.sv - shared types and defaults for the click channel bridges
package click_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETUP    = 2'd1,
    WAIT_ACK = 2'd2
  } click_state_t;

  localparam int CLICK_SYNC_STAGES  = 2;
  localparam int CLICK_SETUP_CYCLES = 1;

endpackage

// File: rtl/click_sync.sv
// rtl/click_sync.sv - N-stage single-bit synchroniser, clears to 0 on reset
module click_sync
  import click_pkg::*;
#(
  parameter int N = CLICK_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [N-1:0] chain;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[N-2:0], d};
    end
  end

  assign q = chain[N-1];

endmodule

// File: rtl/click_sync_tx.sv
// rtl/click_sync_tx.sv - valid/ready stream to 2-phase bundled-data click channel
module click_sync_tx
  import click_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int SYNC_STAGES  = CLICK_SYNC_STAGES,
  parameter int SETUP_CYCLES = CLICK_SETUP_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_req,
  input  logic             out_ack,
  output logic [WIDTH-1:0] out_data,
  output logic             err
);

  // Counter only ever holds SETUP_CYCLES-1 down to 0.
  localparam int CW = $clog2(SETUP_CYCLES + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(SETUP_CYCLES - 1);

  click_state_t     state, state_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic             req_q, req_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             err_q, err_d;
  logic             ack_s;
  logic             ack_match;

  click_sync #(.N(SYNC_STAGES)) u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (out_ack),
    .q     (ack_s)
  );

  assign ack_match = (ack_s == req_q);
  assign in_ready  = (state == IDLE) && rst_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      req_q  <= 1'b0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      req_q  <= req_d;
      data_q <= data_d;
      err_q  <= err_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    req_d   = req_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state)
      IDLE: begin
        // Ack may only move while a token is outstanding.
        if (!ack_match) err_d = 1'b1;
        if (in_valid && in_ready) begin
          data_d  = in_data;
          cnt_d   = CNT_INIT;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (!ack_match) err_d = 1'b1;
        if (cnt == '0) begin
          req_d   = ~req_q;
          state_d = WAIT_ACK;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      WAIT_ACK: begin
        if (ack_match) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_req  = req_q;
  assign out_data = data_q;
  assign err      = err_q;

endmodule

// File: tb/tb_click_sync_tx.sv
// tb/tb_click_sync_tx.sv - self-checking bench for click_sync_tx
module tb_click_sync_tx;

  localparam int SS = 2;
  localparam int SC = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_req;
  logic       out_ack;
  logic [7:0] out_data;
  logic       err;

  logic       resp_en, ack_man;
  logic       resp_ack = 1'b0;
  int         rcnt = 0;
  assign out_ack = resp_en ? resp_ack : ack_man;

  logic       in_valid3, in_ready3, out_req3, out_ack3, err3;
  logic [7:0] in_data3, out_data3;

  click_sync_tx #(.WIDTH(8), .SYNC_STAGES(SS), .SETUP_CYCLES(SC)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_req(out_req), .out_ack(out_ack),
    .out_data(out_data), .err(err)
  );

  click_sync_tx #(.WIDTH(8), .SYNC_STAGES(2), .SETUP_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_data(in_data3), .out_req(out_req3), .out_ack(out_ack3),
    .out_data(out_data3), .err(err3)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a token accepted at edge E toggles req at E+SC
  // and completes at the first later edge whose incoming ack_s equals req.
  // ack_s seen before edge n is out_ack sampled at edge n-SS (0 if that
  // sample predates the last reset).
  bit         m_busy = 0, m_req = 0, m_err = 0, m_live = 0;
  logic [7:0] m_data = 8'h00;
  int         t_toggle = 0, cyc = 0, r_epoch = -100;
  bit         ah[0:16383];

  initial forever begin
    bit acks;
    @(posedge clk);
    if (cyc < 16384) begin
      if (!rst_n) begin
        m_busy = 0; m_req = 0; m_err = 0; m_data = 8'h00;
        r_epoch = cyc; ah[cyc] = 0; m_live = 1;
      end else begin
        acks = (cyc - SS > r_epoch) ? ah[cyc-SS] : 1'b0;
        if (!m_busy) begin
          if (acks != m_req) m_err = 1;
          if (in_valid) begin
            m_busy = 1; m_data = in_data; t_toggle = cyc + SC;
          end
        end else if (cyc <= t_toggle) begin
          if (acks != m_req) m_err = 1;
          if (cyc == t_toggle) m_req = ~m_req;
        end else if (acks == m_req) begin
          m_busy = 0;
        end
        ah[cyc] = out_ack;
      end
      cyc++;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (m_live) begin
      chk("model_in_ready", in_ready, (!m_busy) && rst_n);
      chk("model_out_req", out_req, m_req);
      chk("model_out_data", out_data, m_data);
      chk("model_err", err, m_err);
    end
  end

  // Responder: answers each req toggle two cycles later.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      resp_ack = 1'b0; rcnt = 0;
    end else if (out_req !== resp_ack) begin
      rcnt++;
      if (rcnt >= 2) begin
        resp_ack = out_req; rcnt = 0;
      end
    end else begin
      rcnt = 0;
    end
  end

  int         tog = 0;
  logic       prev_req = 1'b0;
  logic [7:0] seen[$];

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      prev_req = 1'b0;
    end else if (out_req !== prev_req) begin
      tog++;
      seen.push_back(out_data);
      prev_req = out_req;
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [7:0] v);
    in_valid = 1'b1;
    in_data  = v;
    for (int k = 0; k < 100 && !in_ready; k++) @(negedge clk);
    chk("send_ready", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int k = 0; k < 100 && !in_ready; k++) @(negedge clk);
    chk(name, in_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 0; in_valid = 0; in_data = 8'h00; ack_man = 0; resp_en = 0;
    in_valid3 = 0; in_data3 = 8'h00; out_ack3 = 0;

    // Reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_req", out_req, 1'b0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_err", err, 1'b0);
    chk("rst3_out_req", out_req3, 1'b0);
    @(negedge clk) rst_n = 1;
    @(posedge clk) #1;
    chk("rel_in_ready", in_ready, 1'b1);

    // Single token A5
    @(negedge clk);
    in_valid = 1; in_data = 8'hA5;
    @(posedge clk) #1;
    chk("tok_data_e0", out_data, 8'hA5);
    chk("tok_ready_e0", in_ready, 1'b0);
    chk("tok_req_e0", out_req, 1'b0);
    @(negedge clk) in_valid = 0;
    @(posedge clk) #1;
    chk("tok_req_e1", out_req, 1'b1);
    @(posedge clk) #1;
    chk("tok_ready_e2", in_ready, 1'b0);
    @(negedge clk) ack_man = 1;
    @(posedge clk) #1;
    @(posedge clk) #1;
    chk("tok_ready_e4", in_ready, 1'b0);
    @(posedge clk) #1;
    chk("tok_ready_e5", in_ready, 1'b1);
    chk("tok_err_e5", err, 1'b0);
    chk("tok_data_e5", out_data, 8'hA5);

    // Setup margin on the SETUP_CYCLES=3 instance
    @(negedge clk);
    in_valid3 = 1; in_data3 = 8'h3C;
    @(posedge clk) #1;
    chk("s3_data_e0", out_data3, 8'h3C);
    chk("s3_ready_e0", in_ready3, 1'b0);
    @(negedge clk) in_valid3 = 0;
    @(posedge clk) #1;
    chk("s3_req_e1", out_req3, 1'b0);
    @(posedge clk) #1;
    chk("s3_req_e2", out_req3, 1'b0);
    chk("s3_data_e2", out_data3, 8'h3C);
    @(posedge clk) #1;
    chk("s3_req_e3", out_req3, 1'b1);
    @(negedge clk) out_ack3 = 1;
    @(posedge clk) #1;
    @(posedge clk) #1;
    chk("s3_ready_wait", in_ready3, 1'b0);
    @(posedge clk) #1;
    chk("s3_ready_done", in_ready3, 1'b1);
    chk("s3_data_done", out_data3, 8'h3C);
    chk("s3_err", err3, 1'b0);

    // Reset both sides
    @(negedge clk);
    rst_n = 0; ack_man = 0; out_ack3 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;

    // Back-to-back with responder
    resp_en = 1;
    @(posedge clk);
    tog = 0;
    seen.delete();
    @(negedge clk);
    for (int i = 1; i <= 4; i++) send(8'(i));
    wait_idle("b2b_idle");
    chk("b2b_toggles", tog, 4);
    chk("b2b_final_req", out_req, 1'b0);
    chk("b2b_seen_count", seen.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < seen.size()) chk("b2b_seen_data", seen[i], i + 1);
    chk("b2b_err", err, 1'b0);

    // Reset in the middle of WAIT_ACK
    @(negedge clk);
    resp_en = 0; ack_man = 0;
    send(8'h5A);
    @(posedge clk) #1;
    chk("rmw_req", out_req, 1'b1);
    @(negedge clk) rst_n = 0;
    @(posedge clk) #1;
    chk("rmw_req_rst", out_req, 1'b0);
    chk("rmw_data_rst", out_data, 8'h00);
    chk("rmw_err_rst", err, 1'b0);
    @(negedge clk) rst_n = 1;
    #1;
    chk("rmw_ready_rel", in_ready, 1'b1);

    // Spurious ack in IDLE
    @(negedge clk) ack_man = 1;
    @(posedge clk) #1;
    chk("spur_err_e0", err, 1'b0);
    @(posedge clk) #1;
    @(posedge clk) #1;
    chk("spur_err_set", err, 1'b1);
    @(negedge clk);
    send(8'hC3);
    wait_idle("spur_done");
    chk("spur_req", out_req, 1'b1);
    chk("spur_data", out_data, 8'hC3);
    chk("spur_err_sticky", err, 1'b1);

    @(posedge clk) #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
